// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/ORR, iterative MLA (shift-add) and SDIV/UDIV (restoring).
// Latency: ALU ops and divide-by-zero 1 cycle, MLA WIDTH+1, SDIV/UDIV WIDTH+2; done is a one-cycle pulse.
// Backpressure: start is accepted only while busy is low; a start during busy is dropped.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] src_c,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MUL  = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] FIX  = 2'b11;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // a_q: multiplicand / dividend-then-quotient; b_q: multiplier / divisor; acc: accumulator / remainder
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             neg_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;
    logic             is_sdiv;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_dif;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;

    function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    always_comb begin
        sum     = {1'b0, src_a} + {1'b0, src_b};
        dif     = {1'b0, src_a} - {1'b0, src_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            3'b001: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = ~dif[WIDTH];
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b010: alu_res = src_a & src_b;
            3'b011: alu_res = src_a | src_b;
            default: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    // Signed division runs on magnitudes; the most-negative value's magnitude still fits unsigned.
    always_comb begin
        is_sdiv = (ALUControl == 3'b101);
        mag_a   = (is_sdiv && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b   = (is_sdiv && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    always_comb begin
        mul_next = acc + (b_q[0] ? a_q : '0);
        rem_sh   = {acc, a_q[WIDTH-1]};
        rem_dif  = rem_sh - {1'b0, b_q};
        if (rem_dif[WIDTH]) begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {a_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = rem_dif[WIDTH-1:0];
            quo_next = {a_q[WIDTH-2:0], 1'b1};
        end
        quo_fix = neg_q ? -a_q : a_q;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            neg_q       <= 1'b0;
            result      <= '0;
            flags       <= 4'b0000;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (ALUControl)
                            3'b100: begin
                                state <= MUL;
                                cnt   <= '0;
                                a_q   <= src_a;
                                b_q   <= src_b;
                                acc   <= src_c;
                            end
                            3'b101, 3'b110: begin
                                if (src_b == '0) begin
                                    result      <= '0;
                                    flags       <= 4'b0100;
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                end else begin
                                    state <= DIV;
                                    cnt   <= '0;
                                    a_q   <= mag_a;
                                    b_q   <= mag_b;
                                    acc   <= '0;
                                    neg_q <= is_sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                end
                            end
                            default: begin
                                result      <= alu_res;
                                flags       <= alu_flags;
                                div_by_zero <= 1'b0;
                                done        <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result      <= mul_next;
                        flags       <= nz_flags(mul_next);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                DIV: begin
                    acc <= rem_next;
                    a_q <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                default: begin
                    result      <= quo_fix;
                    flags       <= nz_flags(quo_fix);
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed ops push expected result/flags/done-cycle into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   ALUControl;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [W-1:0] src_c;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUControl (ALUControl),
        .src_a      (src_a),
        .src_b      (src_b),
        .src_c      (src_c),
        .result     (result),
        .flags      (flags),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request at a negedge; it is sampled at the following posedge.
    task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] r, input logic [3:0] fl, input logic dbz, input int lat);
        exp_t e;
        start      = 1'b1;
        ALUControl = op;
        src_a      = a;
        src_b      = b;
        src_c      = c;
        e.name = name; e.res = r; e.fl = fl; e.dbz = dbz; e.cyc = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 64'(result), 64'(e.res));
                chk({e.name, "_flags"}, 64'(flags), 64'(e.fl));
                chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_busy"}, 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ALUControl = 3'b000;
        src_a = '0; src_b = '0; src_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result), 0);
        chk("rst_flags", 64'(flags), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_dbz", 64'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops, back to back.
        issue("add",      3'b000, 32'd7,        32'd5,        0, 32'd12,       4'b0000, 0, 1);
        issue("sub_neg",  3'b001, 32'd3,        32'd5,        0, 32'hFFFFFFFE, 4'b1000, 0, 1);
        issue("add_ovf",  3'b000, 32'h7FFFFFFF, 32'd1,        0, 32'h80000000, 4'b1001, 0, 1);
        issue("and",      3'b010, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 4'b0000, 0, 1);
        issue("add_cz",   3'b000, 32'hFFFFFFFF, 32'd1,        0, 32'h0,        4'b0110, 0, 1);
        issue("sub_eq",   3'b001, 32'd5,        32'd5,        0, 32'h0,        4'b0110, 0, 1);
        issue("op111",    3'b111, 32'd2,        32'd3,        0, 32'd5,        4'b0000, 0, 1);

        // MLA with a dropped start while busy.
        issue("mla", 3'b100, 32'd6, 32'd7, 32'd8, 32'd50, 4'b0000, 0, 33);
        repeat (4) @(negedge clk);
        start = 1'b1; ALUControl = 3'b000; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("mla_busy", 64'(busy), 1);
        wait_done("mla");
        issue("mla_wrap", 3'b100, 32'hFFFFFFFF, 32'd2, 32'd3, 32'h00000001, 4'b0000, 0, 33);
        wait_done("mla_wrap");

        // Division.
        issue("sdiv_nm", 3'b101, -32'sd100, 32'd7, 0, 32'hFFFFFFF2, 4'b1000, 0, 34);
        wait_done("sdiv_nm");
        issue("sdiv_pn", 3'b101, 32'd100, -32'sd7, 0, 32'hFFFFFFF2, 4'b1000, 0, 34);
        wait_done("sdiv_pn");
        issue("sdiv_nn", 3'b101, -32'sd100, -32'sd7, 0, 32'd14, 4'b0000, 0, 34);
        wait_done("sdiv_nn");
        issue("udiv", 3'b110, 32'hFFFFFFFF, 32'd16, 0, 32'h0FFFFFFF, 4'b0000, 0, 34);
        wait_done("udiv");
        issue("sdiv_min", 3'b101, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 4'b1000, 0, 34);
        wait_done("sdiv_min");
        issue("sdiv_zero", 3'b101, 32'd0, 32'd5, 0, 32'd0, 4'b0100, 0, 34);
        wait_done("sdiv_zero");
        issue("udiv_b0", 3'b110, 32'd9, 32'd0, 0, 32'd0, 4'b0100, 1, 1);
        issue("add_clr", 3'b000, 32'd1, 32'd1, 0, 32'd2, 4'b0000, 0, 1);

        // Reset during a UDIV abandons it.
        issue("udiv_rst", 3'b110, 32'd100, 32'd3, 0, 32'd33, 4'b0000, 0, 34);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_result", 64'(result), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("orr", 3'b011, 32'h000000F0, 32'h0000000F, 0, 32'h000000FF, 4'b0000, 0, 1);
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
